// File: rtl/snitch_ro_cache_line_splitter.sv
// ---------------------------------------------------------------------------
// snitch_ro_cache_line_splitter
//
// Upstream stage of the read-only cache request path. The block accepts
// cacheable AXI AR bursts (full-width, INCR or FIXED, non-atomic) and splits
// each burst into one lookup request per cache line touched. Every request
// carries the line-aligned address, the AXI ID, the first beat offset within
// the line, the number of beats served from that line, and a burst-last flag.
//
// Optional feature macro: SNITCH_RO_CACHE_LINE_SPLITTER_STATS_EN
//   When defined, two saturating 32-bit counters are exposed:
//   stat_bursts_o (AR handshakes) and stat_lines_o (line handshakes).
//
// Ports:
//   clk_i          clock
//   rst_ni         asynchronous reset, active low
//   ar_addr_i      burst start address
//   ar_id_i        burst ID
//   ar_len_i       AXI len (beats - 1)
//   ar_burst_i     AXI burst type (FIXED = 0, INCR = 1)
//   ar_valid_i     burst valid
//   ar_ready_o     burst accepted
//   line_addr_o    line-aligned request address (low LA bits zero)
//   line_id_o      ID of the owning burst
//   line_offset_o  first beat index within the line
//   line_beats_o   beats served from this line, 1..BPL
//   line_last_o    final request of the burst
//   line_valid_o   request valid
//   line_ready_i   request accepted
//   stat_bursts_o  (stats build only) accepted bursts, saturating
//   stat_lines_o   (stats build only) accepted line requests, saturating
// ---------------------------------------------------------------------------
module snitch_ro_cache_line_splitter #(
  parameter int unsigned AddrWidth = 48,
  parameter int unsigned IdWidth   = 4,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned LineWidth = 256,
  localparam int unsigned Bpl      = LineWidth / DataWidth,
  localparam int unsigned Ow       = (Bpl > 1) ? $clog2(Bpl) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [AddrWidth-1:0] ar_addr_i,
  input  logic [IdWidth-1:0]   ar_id_i,
  input  logic [7:0]           ar_len_i,
  input  logic [1:0]           ar_burst_i,
  input  logic                 ar_valid_i,
  output logic                 ar_ready_o,
  output logic [AddrWidth-1:0] line_addr_o,
  output logic [IdWidth-1:0]   line_id_o,
  output logic [Ow-1:0]        line_offset_o,
  output logic [Ow:0]          line_beats_o,
  output logic                 line_last_o,
  output logic                 line_valid_o,
`ifdef SNITCH_RO_CACHE_LINE_SPLITTER_STATS_EN
  output logic [31:0]          stat_bursts_o,
  output logic [31:0]          stat_lines_o,
`endif
  input  logic                 line_ready_i
);

  localparam int unsigned Fa        = $clog2(DataWidth / 8);
  localparam int unsigned La        = $clog2(LineWidth / 8);
  localparam int unsigned LineBytes = LineWidth / 8;

  localparam logic [AddrWidth-1:0] LowMask   = AddrWidth'(LineBytes - 1);
  localparam logic [AddrWidth-1:0] LineStep  = AddrWidth'(LineBytes);
  localparam logic [Ow-1:0]        OffMask   = Ow'(Bpl - 1);
  localparam logic [Ow:0]          BplBeats  = (Ow + 1)'(Bpl);
  localparam logic [Ow:0]          OneBeat   = {{Ow{1'b0}}, 1'b1};
  localparam logic [1:0]           BurstFixed = 2'd0;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SPLIT = 1'b1
  } state_e;

  // Beat index of an address within its line. The mask makes the
  // single-beat-line case collapse to offset 0; bits below Fa are dropped.
  function automatic logic [Ow-1:0] beat_offset(input logic [AddrWidth-1:0] addr);
    logic [AddrWidth-1:0] shifted;
    shifted     = addr >> Fa;
    beat_offset = shifted[Ow-1:0] & OffMask;
  endfunction

  state_e               state_r;
  logic [AddrWidth-1:0] cur_addr_r;
  logic [8:0]           rem_r;
  logic [IdWidth-1:0]   id_r;
  logic                 fixed_r;

  state_e               nxt_state_s;
  logic [AddrWidth-1:0] nxt_addr_s;
  logic [8:0]           nxt_rem_s;
  logic [IdWidth-1:0]   nxt_id_s;
  logic                 nxt_fixed_s;
  logic                 nxt_valid_s;
  logic                 upd_s;

  logic [AddrWidth-1:0] req_addr_s;
  logic [Ow-1:0]        req_off_s;
  logic [Ow:0]          req_avail_s;
  logic [Ow:0]          req_beats_s;
  logic                 req_last_s;

  logic                 ar_hs_s;
  logic                 line_hs_s;

  // A new burst may enter when idle, or in the very cycle the final line
  // request of the current burst is handed over (zero-bubble chaining).
  assign ar_ready_o = (state_r == ST_IDLE) | (line_valid_o & line_ready_i & line_last_o);
  assign ar_hs_s    = ar_valid_i & ar_ready_o;
  assign line_hs_s  = line_valid_o & line_ready_i;

  // Next burst-tracking state: load a new burst, advance to the next line,
  // or return to idle after the final request.
  always_comb begin
    nxt_state_s = state_r;
    nxt_addr_s  = cur_addr_r;
    nxt_rem_s   = rem_r;
    nxt_id_s    = id_r;
    nxt_fixed_s = fixed_r;
    nxt_valid_s = line_valid_o;
    upd_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (ar_hs_s) begin
          nxt_state_s = ST_SPLIT;
          nxt_addr_s  = ar_addr_i;
          nxt_rem_s   = {1'b0, ar_len_i} + 9'd1;
          nxt_id_s    = ar_id_i;
          nxt_fixed_s = (ar_burst_i == BurstFixed);
          nxt_valid_s = 1'b1;
          upd_s       = 1'b1;
        end else begin
          nxt_valid_s = 1'b0;
        end
      end
      ST_SPLIT: begin
        if (line_hs_s) begin
          if (line_last_o) begin
            if (ar_hs_s) begin
              nxt_addr_s  = ar_addr_i;
              nxt_rem_s   = {1'b0, ar_len_i} + 9'd1;
              nxt_id_s    = ar_id_i;
              nxt_fixed_s = (ar_burst_i == BurstFixed);
              nxt_valid_s = 1'b1;
              upd_s       = 1'b1;
            end else begin
              nxt_state_s = ST_IDLE;
              nxt_valid_s = 1'b0;
            end
          end else begin
            nxt_rem_s = rem_r - 9'(line_beats_o);
            // FIXED bursts revisit the same address; INCR moves to the
            // start of the following line (wrapping at the address top).
            if (fixed_r) begin
              nxt_addr_s = cur_addr_r;
            end else begin
              nxt_addr_s = line_addr_o + LineStep;
            end
            upd_s = 1'b1;
          end
        end else begin
          nxt_valid_s = 1'b1;
        end
      end
      default: begin
        nxt_state_s = ST_IDLE;
        nxt_valid_s = 1'b0;
      end
    endcase
  end

  // Request fields for the line that the next-state address points into.
  always_comb begin
    req_addr_s  = nxt_addr_s & ~LowMask;
    req_off_s   = beat_offset(nxt_addr_s);
    req_avail_s = BplBeats - {1'b0, req_off_s};
    if (nxt_fixed_s) begin
      req_beats_s = OneBeat;
    end else if (nxt_rem_s < 9'(req_avail_s)) begin
      req_beats_s = nxt_rem_s[Ow:0];
    end else begin
      req_beats_s = req_avail_s;
    end
    req_last_s = (9'(req_beats_s) == nxt_rem_s);
  end

  // Burst state and registered request outputs; outputs only change on a
  // load or an accepted non-final request, so a stalled request stays put.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r       <= ST_IDLE;
      cur_addr_r    <= '0;
      rem_r         <= 9'd0;
      id_r          <= '0;
      fixed_r       <= 1'b0;
      line_valid_o  <= 1'b0;
      line_addr_o   <= '0;
      line_id_o     <= '0;
      line_offset_o <= '0;
      line_beats_o  <= '0;
      line_last_o   <= 1'b0;
    end else begin
      state_r      <= nxt_state_s;
      cur_addr_r   <= nxt_addr_s;
      rem_r        <= nxt_rem_s;
      id_r         <= nxt_id_s;
      fixed_r      <= nxt_fixed_s;
      line_valid_o <= nxt_valid_s;
      if (upd_s) begin
        line_addr_o   <= req_addr_s;
        line_id_o     <= nxt_id_s;
        line_offset_o <= req_off_s;
        line_beats_o  <= req_beats_s;
        line_last_o   <= req_last_s;
      end
    end
  end

`ifdef SNITCH_RO_CACHE_LINE_SPLITTER_STATS_EN
  // Saturating handshake counters for burst and line traffic.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stat_bursts_o <= 32'h0000_0000;
      stat_lines_o  <= 32'h0000_0000;
    end else begin
      if (ar_hs_s && (stat_bursts_o != 32'hFFFF_FFFF)) begin
        stat_bursts_o <= stat_bursts_o + 32'd1;
      end
      if (line_hs_s && (stat_lines_o != 32'hFFFF_FFFF)) begin
        stat_lines_o <= stat_lines_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_snitch_ro_cache_line_splitter.sv
// ---------------------------------------------------------------------------
// Testbench for snitch_ro_cache_line_splitter (DataWidth=64, LineWidth=256).
// A reference model expands every accepted burst into its beat addresses,
// groups consecutive beats by line and queues the expected requests; a
// monitor compares every presented request, AR readiness and stall stability.
// ---------------------------------------------------------------------------
module tb_snitch_ro_cache_line_splitter;

  localparam int AW = 48;
  localparam int IW = 4;
  localparam int DB = 8;   // bytes per beat
  localparam int LB = 32;  // bytes per line

  typedef struct {
    logic [AW-1:0] addr;
    logic [IW-1:0] id;
    logic [1:0]    off;
    logic [2:0]    beats;
    logic          last;
  } req_t;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic [AW-1:0] ar_addr_i = '0;
  logic [IW-1:0] ar_id_i = '0;
  logic [7:0]    ar_len_i = '0;
  logic [1:0]    ar_burst_i = 2'd1;
  logic          ar_valid_i = 1'b0;
  logic          ar_ready_o;
  logic [AW-1:0] line_addr_o;
  logic [IW-1:0] line_id_o;
  logic [1:0]    line_offset_o;
  logic [2:0]    line_beats_o;
  logic          line_last_o;
  logic          line_valid_o;
  logic          line_ready_i = 1'b0;

  req_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   ready_force = 1;  // 0 random, 1 always high, 2 always low

  snitch_ro_cache_line_splitter #(
    .AddrWidth(AW), .IdWidth(IW), .DataWidth(64), .LineWidth(256)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .ar_addr_i    (ar_addr_i),
    .ar_id_i      (ar_id_i),
    .ar_len_i     (ar_len_i),
    .ar_burst_i   (ar_burst_i),
    .ar_valid_i   (ar_valid_i),
    .ar_ready_o   (ar_ready_o),
    .line_addr_o  (line_addr_o),
    .line_id_o    (line_id_o),
    .line_offset_o(line_offset_o),
    .line_beats_o (line_beats_o),
    .line_last_o  (line_last_o),
    .line_valid_o (line_valid_o),
    .line_ready_i (line_ready_i)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expand the burst into beat addresses, then group consecutive INCR beats
  // that fall into the same line; FIXED beats are one request each.
  task automatic model_push(input logic [AW-1:0] a, input logic [7:0] len,
                            input logic [1:0] bt, input logic [IW-1:0] id);
    logic [AW-1:0] base, b, line, nb;
    int n, k, cnt;
    req_t r;
    base = a & ~AW'(DB - 1);
    n = int'(len) + 1;
    k = 0;
    while (k < n) begin
      b = (bt == 2'd0) ? base : base + AW'(k * DB);
      line = b & ~AW'(LB - 1);
      cnt = 1;
      if (bt == 2'd1) begin
        while (k + cnt < n) begin
          nb = base + AW'((k + cnt) * DB);
          if ((nb & ~AW'(LB - 1)) != line) break;
          cnt++;
        end
      end
      r.addr  = line;
      r.id    = id;
      r.off   = 2'((b - line) / AW'(DB));
      r.beats = 3'(cnt);
      r.last  = (k + cnt == n);
      exp_q.push_back(r);
      k += cnt;
    end
  endtask

  // Downstream ready generator.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_force)
        0: line_ready_i = ($urandom_range(0, 3) != 0);
        1: line_ready_i = 1'b1;
        default: line_ready_i = 1'b0;
      endcase
    end
  end

  // Monitor: compares presented requests, AR readiness and stall stability.
  initial begin
    req_t held;
    logic held_valid;
    logic was_stall;
    logic exp_rdy;
    was_stall = 1'b0;
    held_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_ni) begin
        was_stall = 1'b0;
      end else begin
        if (line_valid_o) exp_rdy = line_ready_i && (exp_q.size() > 0) && exp_q[0].last;
        else exp_rdy = 1'b1;
        check("ar_ready", 64'(ar_ready_o), 64'(exp_rdy));
        if (was_stall) begin
          check("stall_valid", 64'(line_valid_o), 64'(held_valid));
          check("stall_addr", 64'(line_addr_o), 64'(held.addr));
          check("stall_beats", 64'({line_id_o, line_offset_o, line_beats_o, line_last_o}),
                64'({held.id, held.off, held.beats, held.last}));
        end
        if (line_valid_o) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_req: got addr %0h with no request expected", line_addr_o);
          end else begin
            check("req_addr", 64'(line_addr_o), 64'(exp_q[0].addr));
            check("req_id", 64'(line_id_o), 64'(exp_q[0].id));
            check("req_off", 64'(line_offset_o), 64'(exp_q[0].off));
            check("req_beats", 64'(line_beats_o), 64'(exp_q[0].beats));
            check("req_last", 64'(line_last_o), 64'(exp_q[0].last));
            if (line_ready_i) void'(exp_q.pop_front());
          end
        end
        was_stall = line_valid_o && !line_ready_i;
        held_valid = line_valid_o;
        held.addr = line_addr_o;
        held.id = line_id_o;
        held.off = line_offset_o;
        held.beats = line_beats_o;
        held.last = line_last_o;
      end
    end
  end

  // Issue one burst; call at a negedge. Returns at a negedge with the
  // cycle stamp of the AR handshake.
  task automatic send_ar(input logic [AW-1:0] a, input logic [7:0] len,
                         input logic [1:0] bt, input logic [IW-1:0] id, output int hs_cyc);
    int waited;
    ar_addr_i = a;
    ar_len_i = len;
    ar_burst_i = bt;
    ar_id_i = id;
    ar_valid_i = 1'b1;
    waited = 0;
    hs_cyc = -1;
    while (!ar_ready_o && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    if (!ar_ready_o) begin
      checks++;
      errors++;
      $display("FAIL ar_timeout: got no ar_ready within %0d cycles, required a handshake", waited);
      ar_valid_i = 1'b0;
    end else begin
      model_push(a, len, bt, id);
      @(posedge clk);
      #1;
      hs_cyc = cyc;
      ar_valid_i = 1'b0;
      @(negedge clk);
      check("first_req_latency", 64'(line_valid_o), 64'd1);
    end
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    while ((exp_q.size() != 0 || line_valid_o) && waited < 4000) begin
      @(negedge clk);
      waited++;
    end
    check("drain_pending", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int h1, h2, waited;
    logic [AW-1:0] ra;
    logic [7:0] rl;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_valid", 64'(line_valid_o), 64'd0);
    check("rst_addr", 64'(line_addr_o), 64'd0);
    check("rst_fields", 64'({line_id_o, line_offset_o, line_beats_o, line_last_o}), 64'd0);
    rst_ni = 1'b1;
    @(negedge clk);
    check("rst_ar_ready", 64'(ar_ready_o), 64'd1);

    // T1..T3: single line, two lines, FIXED
    ready_force = 1;
    repeat (2) @(negedge clk);
    send_ar(48'h1000, 8'd3, 2'd1, 4'd5, h1);
    send_ar(48'h1010, 8'd5, 2'd1, 4'd6, h1);
    send_ar(48'h1018, 8'd2, 2'd0, 4'd9, h1);
    drain();

    // T4: stalled first request must hold and block AR
    ready_force = 2;
    repeat (2) @(negedge clk);
    send_ar(48'h1010, 8'd5, 2'd1, 4'd7, h1);
    repeat (5) @(negedge clk);
    ready_force = 1;
    waited = 0;
    while (!(line_valid_o && line_ready_i) && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    @(negedge clk);
    check("t4_req2_valid", 64'(line_valid_o), 64'd1);
    check("t4_req2_addr", 64'(line_addr_o), 64'h1020);
    drain();

    // T5: back-to-back single-beat bursts, no bubble
    repeat (2) @(negedge clk);
    send_ar(48'h2000, 8'd0, 2'd1, 4'd1, h1);
    send_ar(48'h3008, 8'd0, 2'd1, 4'd2, h2);
    check("t5_back_to_back", 64'(h2 - h1), 64'd1);
    check("t5_second_off", 64'(line_offset_o), 64'd1);
    drain();

    // T6: wrap at the address top, reset after the first request
    ready_force = 2;
    repeat (2) @(negedge clk);
    send_ar(48'hFFFF_FFFF_FFF0, 8'd3, 2'd1, 4'd3, h1);
    ready_force = 1;
    @(negedge clk);
    ready_force = 2;
    @(posedge clk);
    #2;
    rst_ni = 1'b0;
    #1;
    check("t6_rst_valid", 64'(line_valid_o), 64'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t6_no_req2", 64'(line_valid_o), 64'd0);
    end

    // Random bursts with random backpressure
    ready_force = 0;
    for (int i = 0; i < 50; i++) begin
      ra = AW'({$urandom, $urandom});
      if ($urandom_range(0, 5) == 0) ra[AW-1:8] = '1;
      rl = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 12));
      send_ar(ra, rl, ($urandom_range(0, 3) == 0) ? 2'd0 : 2'd1, 4'($urandom_range(0, 15)), h1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
